// File: rtl/pipe_reg_elastic_pkg.sv
// pipe_pkg: shared depth limits, stage control encoding and count-width helper
// for the elastic pipeline register.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    // Per-stage control issued by the chain logic each cycle.
    typedef enum logic [1:0] {
        STG_HOLD  = 2'd0,
        STG_LOAD  = 2'd1,
        STG_CLEAR = 2'd2
    } stage_op_e;

    // Width of the occupancy counter: must hold DEPTH stages plus one skid entry.
    function automatic int pipe_count_w(input int depth);
        int d;
        d = (depth > PIPE_MAX_DEPTH) ? PIPE_MAX_DEPTH : depth;
        return $clog2(d + 2);
    endfunction

endpackage

// File: rtl/pipe_reg_elastic_stage.sv
// pipe_stage: one data+valid register of the elastic chain.
// Load takes the source valid and only overwrites data when the source is valid,
// so the last delivered payload stays visible on an empty stage.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  stage_op_e        i_op,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Stage register: reset, load from source, clear valid (flush) or hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else begin
            case (i_op)
                STG_LOAD: begin
                    r_valid <= i_valid;
                    if (i_valid) begin
                        r_data <= i_data;
                    end
                end
                STG_CLEAR: r_valid <= 1'b0;
                default:   ;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: chain of DEPTH elastic stages with valid/ready handshake,
// bubble collapsing, global stall and synchronous flush.
// Optional macro PIPE_REG_ELASTIC_SKID_EN adds a one-entry skid ahead of stage 0
// and makes in_ready come from a flop, breaking the out_ready->in_ready path.
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [WIDTH-1:0]                i_in,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [WIDTH-1:0]                o_out,
    output logic [pipe_count_w(DEPTH)-1:0]  o_count
);

    localparam int CW = pipe_count_w(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH:0]   w_rdy;
    stage_op_e        w_op [DEPTH];

    logic             w_go;
    logic             w_acc;
    logic             w_xfer_out;
    logic             w_src0_valid;
    logic [WIDTH-1:0] w_src0_data;
    logic [CW-1:0]    r_count;

    assign w_go = !i_stall && !i_flush;

    // Ready ripples back from the output: an empty stage is always ready,
    // which is what lets bubbles collapse while downstream is blocked.
    always_comb begin
        w_rdy[DEPTH] = i_out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = !w_valid[i] || w_rdy[i+1];
        end
    end

`ifdef PIPE_REG_ELASTIC_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;
    logic             w_skid_valid_nxt;

    // Stall/flush still gate the flop so nothing is taken in a frozen cycle.
    assign o_in_ready   = r_in_ready && w_go;
    assign w_acc        = i_in_valid && o_in_ready;
    assign w_src0_valid = r_skid_valid || w_acc;
    assign w_src0_data  = r_skid_valid ? r_skid_data : i_in;

    // Skid occupancy: holds an entry accepted while stage 0 was blocked and
    // drains it into stage 0 first; while full, the registered in_ready is low.
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (i_flush) begin
            w_skid_valid_nxt = 1'b0;
        end else if (w_go) begin
            if (r_skid_valid) begin
                w_skid_valid_nxt = !w_rdy[0];
            end else begin
                w_skid_valid_nxt = w_acc && !w_rdy[0];
            end
        end
    end

    // Skid register and the registered in_ready derived from its next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= RST_VAL;
            r_in_ready   <= 1'b1;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_acc && !r_skid_valid && !w_rdy[0]) begin
                r_skid_data <= i_in;
            end
        end
    end
`else
    assign o_in_ready   = w_rdy[0] && w_go;
    assign w_acc        = i_in_valid && o_in_ready;
    assign w_src0_valid = w_acc;
    assign w_src0_data  = i_in;
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (gi == 0) begin : g_head
            assign w_src_valid = w_src0_valid;
            assign w_src_data  = w_src0_data;
        end else begin : g_body
            assign w_src_valid = w_valid[gi-1];
            assign w_src_data  = w_data[gi-1];
        end

        assign w_op[gi] = i_flush                ? STG_CLEAR :
                          (w_go && w_rdy[gi])    ? STG_LOAD  :
                                                   STG_HOLD;

        pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_op    (w_op[gi]),
            .i_valid (w_src_valid),
            .i_data  (w_src_data),
            .o_valid (w_valid[gi]),
            .o_data  (w_data[gi])
        );
    end

    assign o_out       = w_data[DEPTH-1];
    assign o_out_valid = w_valid[DEPTH-1] && w_go;
    assign w_xfer_out  = o_out_valid && i_out_ready;

    // Occupancy: +1 per accepted input, -1 per delivered output, zeroed on flush.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_acc) - CW'(w_xfer_out);
        end
    end

    assign o_count = r_count;

endmodule
